// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides clkin by 4 into a pixel strobe and produces
// registered sync, blanking, position and line/frame boundary outputs.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       en,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    // Totals above 1024 do not fit the 10-bit counters and are unsupported.
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] H_FRONT_AT = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_AT  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BACK_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] V_FRONT_AT = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_AT  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BACK_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;

    logic [1:0] prescale;
    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    h_state_t   h_state;
    h_state_t   h_next;
    v_state_t   v_state;
    v_state_t   v_next;

    assign tick   = en && (prescale == 2'd3);
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            prescale <= 2'd0;
        end else if (en) begin
            prescale <= prescale + 2'd1;
        end
    end

    // h_cnt/v_cnt hold the position that the next tick will present on the outputs.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (tick) begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            h_state <= H_ACT;
            v_state <= V_ACT;
        end else if (tick) begin
            h_state <= h_next;
            v_state <= v_next;
        end
    end

    always_comb begin
        h_next = h_state;
        case (h_state)
            H_ACT:   if (h_cnt == H_FRONT_AT) h_next = H_FRONT;
            H_FRONT: if (h_cnt == H_SYNC_AT)  h_next = H_SYNCP;
            H_SYNCP: if (h_cnt == H_BACK_AT)  h_next = H_BACK;
            H_BACK:  if (h_cnt == 10'd0)      h_next = H_ACT;
            default: h_next = H_ACT;
        endcase
    end

    // The vertical phase only moves when a new line is being presented.
    always_comb begin
        v_next = v_state;
        if (h_cnt == 10'd0) begin
            case (v_state)
                V_ACT:   if (v_cnt == V_FRONT_AT) v_next = V_FRONT;
                V_FRONT: if (v_cnt == V_SYNC_AT)  v_next = V_SYNCP;
                V_SYNCP: if (v_cnt == V_BACK_AT)  v_next = V_BACK;
                V_BACK:  if (v_cnt == 10'd0)      v_next = V_ACT;
                default: v_next = V_ACT;
            endcase
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
        end else begin
            pix_tick    <= tick;
            line_start  <= tick && (h_cnt == 10'd0) && (pixel_x == H_LAST);
            frame_start <= tick && (h_cnt == 10'd0) && (v_cnt == 10'd0)
                           && (pixel_x == H_LAST) && (pixel_y == V_LAST);
            if (tick) begin
                pixel_x  <= h_cnt;
                pixel_y  <= v_cnt;
                hsync    <= (h_next != H_SYNCP);
                vsync    <= (v_next != V_SYNCP);
                video_on <= (h_next == H_ACT) && (v_next == V_ACT);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken 32x15 raster: a tick-count model feeds a
// scoreboard queue, and directed steps probe reset, porches, wrap and enable gaps.
module tb_vga_sync_gen;

    localparam int HA = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VA = 8;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NPIX = HT * VT;
    localparam int LIMIT = 8 * NPIX;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;

    typedef struct {
        int   px;
        int   py;
        logic hs;
        logic vs;
        logic von;
        logic ls;
        logic fs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   check_count = 0;
    int   pass_count = 0;
    int   m_pre = 0;
    int   m_ticks = 0;
    logic m_tick_last = 1'b0;
    int   last_px = 0;
    int   last_py = 0;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .en(en),
        .pix_tick(pix_tick),
        .hsync(hsync),
        .vsync(vsync),
        .video_on(video_on),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .line_start(line_start),
        .frame_start(frame_start)
    );

    always #5 clkin = ~clkin;

    initial begin
        #(60000 * 10);
        $display("[TB] FAIL watchdog: observed time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // Tick k presents raster position k-1; boundary pulses only on a real wrap.
    function automatic exp_t expected_for(int k);
        exp_t e;
        int   idx;
        idx   = k - 1;
        e.px  = idx % HT;
        e.py  = (idx / HT) % VT;
        e.hs  = !((e.px >= HA + HF) && (e.px < HA + HF + HS));
        e.vs  = !((e.py >= VA + VF) && (e.py < VA + VF + VS));
        e.von = (e.px < HA) && (e.py < VA);
        e.ls  = (k >= 2) && (e.px == 0);
        e.fs  = e.ls && (e.py == 0);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic r, input logic e);
        @(negedge clkin);
        reset = r;
        en    = e;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_pix_tick", 32'(pix_tick), 0);
        checkOutput("rst_line_start", 32'(line_start), 0);
        checkOutput("rst_frame_start", 32'(frame_start), 0);
        checkOutput("rst_hsync", 32'(hsync), 1);
        checkOutput("rst_vsync", 32'(vsync), 1);
        checkOutput("rst_video_on", 32'(video_on), 1);
        checkOutput("rst_pixel_x", 32'(pixel_x), 0);
        checkOutput("rst_pixel_y", 32'(pixel_y), 0);
    endtask

    always @(posedge clkin or posedge reset) begin
        if (reset) begin
            m_pre       = 0;
            m_ticks     = 0;
            m_tick_last = 1'b0;
            exp_q.delete();
        end else begin
            m_tick_last = 1'b0;
            if (en) begin
                if (m_pre == 3) begin
                    m_ticks++;
                    exp_q.push_back(expected_for(m_ticks));
                    m_tick_last = 1'b1;
                end
                m_pre = (m_pre + 1) % 4;
            end
        end
    end

    // Scoreboard consumer: pops on each strobe, otherwise everything must hold still.
    always @(negedge clkin) begin
        if (reset) begin
            last_px = 0;
            last_py = 0;
        end else begin
            checkOutput("sb_pix_tick", 32'(pix_tick), 32'(m_tick_last));
            if (pix_tick && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_pixel_x", 32'(pixel_x), mon_e.px);
                checkOutput("sb_pixel_y", 32'(pixel_y), mon_e.py);
                checkOutput("sb_hsync", 32'(hsync), 32'(mon_e.hs));
                checkOutput("sb_vsync", 32'(vsync), 32'(mon_e.vs));
                checkOutput("sb_video_on", 32'(video_on), 32'(mon_e.von));
                checkOutput("sb_line_start", 32'(line_start), 32'(mon_e.ls));
                checkOutput("sb_frame_start", 32'(frame_start), 32'(mon_e.fs));
                last_px = mon_e.px;
                last_py = mon_e.py;
            end else if (!pix_tick) begin
                checkOutput("idle_line_start", 32'(line_start), 0);
                checkOutput("idle_frame_start", 32'(frame_start), 0);
                checkOutput("hold_pixel_x", 32'(pixel_x), last_px);
                checkOutput("hold_pixel_y", 32'(pixel_y), last_py);
            end
        end
    end

    initial begin
        int         n;
        int         first_tick;
        logic       prev_von;
        logic [9:0] held_x;
        logic [9:0] held_y;
        logic       held_hs;
        logic       held_von;

        reset = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clkin);
        checkResetValues();

        // Release: first strobe on edge 4, position 1 presented on edge 8.
        applyStimulus(1'b0, 1'b1);
        first_tick = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clkin);
            #1;
            if (pix_tick && first_tick == 0) first_tick = e;
            if (e == 7) checkOutput("px_before_second_tick", 32'(pixel_x), 0);
        end
        checkOutput("first_tick_edge", first_tick, 4);
        checkOutput("tick_at_edge8", 32'(pix_tick), 1);
        checkOutput("px_after_8_edges", 32'(pixel_x), 1);

        n = 0;
        do begin
            prev_von = video_on;
            @(negedge clkin);
            n++;
        end while (!(prev_von && !video_on) && n < LIMIT);
        checkOutput("video_on_fall_seen", 32'(prev_von && !video_on), 1);
        checkOutput("video_on_fall_px", 32'(pixel_x), HA);

        n = 0;
        while (hsync && n < LIMIT) begin @(negedge clkin); n++; end
        checkOutput("hsync_fall_seen", 32'(!hsync), 1);
        checkOutput("hsync_fall_px", 32'(pixel_x), HA + HF);
        n = 0;
        while (!hsync && n < LIMIT) begin @(negedge clkin); n++; end
        checkOutput("hsync_low_cycles", n, HS * 4);

        n = 0;
        while (!line_start && n < LIMIT) begin @(negedge clkin); n++; end
        checkOutput("line_start_seen", 32'(line_start), 1);
        n = 0;
        do begin @(negedge clkin); n++; end while (!line_start && n < LIMIT);
        checkOutput("line_start_period", n, HT * 4);

        n = 0;
        while (vsync && n < LIMIT) begin @(negedge clkin); n++; end
        checkOutput("vsync_fall_seen", 32'(!vsync), 1);
        checkOutput("vsync_fall_py", 32'(pixel_y), VA + VF);
        checkOutput("vsync_fall_px", 32'(pixel_x), 0);
        n = 0;
        while (!vsync && n < LIMIT) begin @(negedge clkin); n++; end
        checkOutput("vsync_low_cycles", n, VS * HT * 4);

        n = 0;
        while (!frame_start && n < LIMIT) begin @(negedge clkin); n++; end
        checkOutput("frame_start_seen", 32'(frame_start), 1);
        checkOutput("frame_with_line_a", 32'(line_start), 1);
        n = 0;
        do begin @(negedge clkin); n++; end while (!frame_start && n < LIMIT);
        checkOutput("frame_start_period", n, NPIX * 4);
        checkOutput("frame_with_line_b", 32'(line_start), 1);

        // Last raster position, then the wrapping tick.
        n = 0;
        while (!(pixel_x == 10'(HT - 1) && pixel_y == 10'(VT - 1) && !pix_tick) && n < LIMIT) begin
            @(negedge clkin);
            n++;
        end
        checkOutput("corner_reached", 32'(pixel_x == 10'(HT - 1) && pixel_y == 10'(VT - 1)), 1);
        n = 0;
        while (!pix_tick && n < 8) begin @(negedge clkin); n++; end
        checkOutput("wrap_tick_seen", 32'(pix_tick), 1);
        checkOutput("wrap_pixel_x", 32'(pixel_x), 0);
        checkOutput("wrap_pixel_y", 32'(pixel_y), 0);
        checkOutput("wrap_video_on", 32'(video_on), 1);
        checkOutput("wrap_hsync", 32'(hsync), 1);
        checkOutput("wrap_vsync", 32'(vsync), 1);
        checkOutput("wrap_line_start", 32'(line_start), 1);
        checkOutput("wrap_frame_start", 32'(frame_start), 1);

        // Seven disabled edges right after the strobe that presents x=10.
        n = 0;
        while (!(pix_tick && pixel_x == 10'd10) && n < LIMIT) begin @(negedge clkin); n++; end
        checkOutput("gap_start_seen", 32'(pix_tick && pixel_x == 10'd10), 1);
        held_x   = pixel_x;
        held_y   = pixel_y;
        held_hs  = hsync;
        held_von = video_on;
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clkin);
            checkOutput("gap_pixel_x", 32'(pixel_x), 32'(held_x));
            checkOutput("gap_pixel_y", 32'(pixel_y), 32'(held_y));
            checkOutput("gap_hsync", 32'(hsync), 32'(held_hs));
            checkOutput("gap_video_on", 32'(video_on), 32'(held_von));
            checkOutput("gap_pix_tick", 32'(pix_tick), 0);
            checkOutput("gap_line_start", 32'(line_start), 0);
            checkOutput("gap_frame_start", 32'(frame_start), 0);
        end
        en = 1'b1;
        n = 7;
        while (!pix_tick && n < 40) begin @(negedge clkin); n++; end
        checkOutput("gap_tick_spacing", n, 4 + 7);
        checkOutput("gap_resume_px", 32'(pixel_x), 11);

        // Asynchronous reset in the middle of the vsync pulse and hsync pulse.
        n = 0;
        while (!(pixel_y == 10'(VA + VF + 1) && pixel_x == 10'(HA + HF + 2)) && n < LIMIT) begin
            @(negedge clkin);
            n++;
        end
        checkOutput("pre_reset_vsync_low", 32'(vsync), 0);
        checkOutput("pre_reset_hsync_low", 32'(hsync), 0);
        #1 reset = 1'b1;
        #1 checkResetValues();
        repeat (2) @(negedge clkin);
        applyStimulus(1'b0, 1'b1);
        n = 0;
        while (!frame_start && n < 4 * NPIX + 64) begin @(negedge clkin); n++; end
        checkOutput("post_reset_frame_start", n, 4 * NPIX + 4);
        checkOutput("post_reset_frame_line", 32'(line_start), 1);

        @(negedge clkin);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Port clkin, input, 1: 100 MHz master clock; all logic SHALL be clocked on its rising edge.
REQ-010 Port reset, input, 1: reset, asynchronous, active-high.
REQ-011 Port en, input, 1: run enable; low freezes all timing state.
REQ-012 Port pix_tick, output, 1: one-clkin-cycle 25 MHz pixel strobe.
REQ-013 Ports hsync and vsync, output, 1 each: active-low sync pulses.
REQ-014 Port video_on, output, 1: high while in the visible region.
REQ-015 Ports pixel_x and pixel_y, output, 10 each: current horizontal and vertical counts.
REQ-016 Ports line_start and frame_start, output, 1 each: one-clkin-cycle boundary pulses.

Function
REQ-017 Totals H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOT (525) SHALL each be at most 1024; larger values are unsupported.
REQ-018 A 2-bit prescaler SHALL advance by 1 on every clkin edge while en=1, wrapping from 3 to 0.
REQ-019 pix_tick SHALL be high for exactly the one clkin cycle in which the prescaler equals 3 and en=1, giving a period of 4 clkin cycles.
REQ-020 The horizontal count SHALL advance only on pix_tick, wrapping from H_TOT-1 to 0.
REQ-021 The vertical count SHALL advance only on pix_tick when the horizontal count wraps, wrapping from V_TOT-1 to 0.
REQ-022 The horizontal phase FSM SHALL use states H_ACT, H_FRONT, H_SYNCP and H_BACK, with transitions:
- H_ACT to H_FRONT at h=H_ACTIVE
- H_FRONT to H_SYNCP at h=H_ACTIVE+H_FP
- H_SYNCP to H_BACK at h=H_ACTIVE+H_FP+H_SYNC
- H_BACK to H_ACT at the wrap to 0
REQ-023 An equivalent vertical FSM (V_ACT, V_FRONT, V_SYNCP, V_BACK) SHALL step only at horizontal wrap.
REQ-024 hsync SHALL be 0 exactly while in H_SYNCP (h in 656..751 by default), else 1.
REQ-025 vsync SHALL be 0 exactly while in V_SYNCP (v in 490..491 by default), else 1.
REQ-026 video_on SHALL be 1 exactly while in both H_ACT and V_ACT.
REQ-027 pixel_x and pixel_y SHALL equal the raw horizontal and vertical counts, including blanking values.
REQ-028 All outputs SHALL be registered, with no combinational path from input to output.
REQ-029 hsync, vsync, video_on, pixel_x and pixel_y SHALL change in the same clkin cycle as the counts they decode, with zero-cycle skew between them.
REQ-030 line_start SHALL pulse for one clkin cycle in the cycle after the tick that wraps h to 0.
REQ-031 frame_start SHALL pulse only in the cycle where both h and v have just wrapped to 0, and SHALL coincide with line_start.
REQ-032 While en=0, the block SHALL:
- hold the prescaler, counts, FSM states, hsync, vsync, video_on, pixel_x and pixel_y
- force pix_tick, line_start and frame_start to 0
REQ-033 When en rises, the prescaler SHALL resume from its held value, with no extra or lost tick.

Reset
REQ-034 While reset=1, regardless of clkin or en:
- prescaler=0, h=0, v=0, FSMs in H_ACT and V_ACT
- pix_tick=0, line_start=0, frame_start=0
- hsync=1, vsync=1, video_on=1, pixel_x=0, pixel_y=0
REQ-035 Asserting reset mid-frame SHALL abort the frame immediately, without completing the current line or sync pulse.
REQ-036 After reset deasserts with en=1, the first pix_tick SHALL occur on the 4th clkin edge.

Verification
REQ-037 Reset release with en=1: check that pix_tick first fires on edge 4, then every 4 cycles; h reaches 1 after 8 edges.
REQ-038 Horizontal line: check that hsync falls when h=656, stays low for 384 clkin cycles, and that video_on falls at h=640; line_start pulses every 3200 clkin cycles.
REQ-039 Vertical frame: check that vsync is low for exactly 2 lines (6400 clkin cycles) starting at v=490, and that frame_start pulses every 1,680,000 clkin cycles, coincident with line_start.
REQ-040 Drop en for 7 cycles mid-line at h=300: check that all outputs hold, no pulses occur, and the tick spacing across the gap equals 4 enabled cycles.
REQ-041 Assert reset during the vsync pulse (v=491, h=700): check that all outputs show reset values within the same cycle, and that the next frame_start occurs 1,680,000 cycles after release.
REQ-042 Wrap corner: check that at h=799, v=524, the next tick gives h=0, v=0, video_on=1, hsync=1, vsync=1, and both pulses fire.
